// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the core's two memory ports, the arbiter
// and the shared memory.
//   master : arbiter view. Takes fetch/data requests and memory responses,
//            drives the ready/rdata returns, the memory request bus and timeout.
//   slave  : environment view (core + memory), the mirror image of master.
// Signals:
//   if_req/if_addr -> if_rdata/if_ready              instruction fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready     data load/store port
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack   memory side
//   timeout                                          watchdog abort pulse
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          timeout;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, timeout
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_req, mem_we, mem_addr, mem_wdata, timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port
// and the data load/store port. One access is in flight at a time; the
// granted port is held until mem_ack, or until the watchdog aborts the access.
// Every output is registered.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : mem_port_arbiter_if.master (fetch, data and memory signal groups)
// Parameters:
//   AW, DW  : address / data width
//   RR_EN   : 1 = round-robin on contention, 0 = data port always wins
//   TIMEOUT : ack-less grant cycles tolerated before abort (1..255)
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  // wdog counts ack-less grant cycles already elapsed, so the cycle in
  // which it equals TIMEOUT-1 is the last one an ack is accepted in.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_next;
  port_t         rr_last, rr_last_next;
  logic [7:0]    wdog, wdog_next;
  logic          mem_req_next, mem_we_next, if_ready_next, d_ready_next;
  logic          timeout_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next, if_rdata_next, d_rdata_next;
  logic          bubble, grant_d, grant_if;

  always_comb begin
    state_next     = state;
    rr_last_next   = rr_last;
    wdog_next      = wdog;
    mem_req_next   = bus.mem_req;
    mem_we_next    = bus.mem_we;
    mem_addr_next  = bus.mem_addr;
    mem_wdata_next = bus.mem_wdata;
    if_rdata_next  = bus.if_rdata;
    d_rdata_next   = bus.d_rdata;
    if_ready_next  = 1'b0;
    d_ready_next   = 1'b0;
    timeout_next   = 1'b0;

    // The requester that just saw ready still holds req this cycle, so the
    // cycle carrying a ready pulse is a bubble in which nothing is granted.
    bubble   = bus.if_ready | bus.d_ready;
    grant_d  = bus.d_req & (~bus.if_req | (RR_EN == 0) | (rr_last == PORT_IF));
    grant_if = bus.if_req & ~grant_d;

    unique case (state)
      IDLE: begin
        if (!bubble && grant_d) begin
          state_next     = GNT_D;
          mem_req_next   = 1'b1;
          mem_we_next    = bus.d_we;
          mem_addr_next  = bus.d_addr;
          mem_wdata_next = bus.d_wdata;
          wdog_next      = '0;
        end else if (!bubble && grant_if) begin
          state_next     = GNT_IF;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = bus.if_addr;
          mem_wdata_next = '0;
          wdog_next      = '0;
        end
      end
      GNT_IF, GNT_D: begin
        // An ack in the final watchdog cycle still completes normally.
        if (bus.mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          if (state == GNT_IF) begin
            if_ready_next = 1'b1;
            if_rdata_next = bus.mem_rdata;
            rr_last_next  = PORT_IF;
          end else begin
            d_ready_next = 1'b1;
            d_rdata_next = bus.mem_rdata;
            rr_last_next = PORT_D;
          end
        end else if (wdog == WDOG_LAST) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          timeout_next = 1'b1;
          if (state == GNT_IF) begin
            if_ready_next = 1'b1;
            if_rdata_next = '0;
          end else begin
            d_ready_next = 1'b1;
            d_rdata_next = '0;
          end
        end else begin
          wdog_next = wdog + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_last       <= PORT_IF;
      wdog          <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      state         <= state_next;
      rr_last       <= rr_last_next;
      wdog          <= wdog_next;
      bus.mem_req   <= mem_req_next;
      bus.mem_we    <= mem_we_next;
      bus.mem_addr  <= mem_addr_next;
      bus.mem_wdata <= mem_wdata_next;
      bus.if_rdata  <= if_rdata_next;
      bus.d_rdata   <= d_rdata_next;
      bus.if_ready  <= if_ready_next;
      bus.d_ready   <= d_ready_next;
      bus.timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share clk/rst:
//   dut_a : fixed priority (RR_EN=0), TIMEOUT=255
//   dut_b : round-robin   (RR_EN=1), TIMEOUT=4
// Inputs change 1ns after a rising edge; outputs are sampled at that same
// point, i.e. they show what the preceding edge registered.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) ia ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) ib ();

  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(0), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.master)
  );
  mem_port_arbiter #(.AW(32), .DW(32), .RR_EN(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.if_req = 0; ia.if_addr = '0; ia.d_req = 0; ia.d_we = 0; ia.d_addr = '0;
    ia.d_wdata = '0; ia.mem_rdata = '0; ia.mem_ack = 0;
    ib.if_req = 0; ib.if_addr = '0; ib.d_req = 0; ib.d_we = 0; ib.d_addr = '0;
    ib.d_wdata = '0; ib.mem_rdata = '0; ib.mem_ack = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (ia.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", ia.mem_req); else passed++;
    checks++; if ({ia.if_ready, ia.d_ready, ia.timeout} !== 3'b000) $display("FAIL rst_pulses got %b exp 000", {ia.if_ready, ia.d_ready, ia.timeout}); else passed++;
    checks++; if ({ia.if_rdata, ia.d_rdata} !== 64'h0) $display("FAIL rst_rdata got %h exp 0", {ia.if_rdata, ia.d_rdata}); else passed++;
    checks++; if ({ia.mem_addr, ia.mem_wdata, ia.mem_we} !== 65'h0) $display("FAIL rst_mem_bus got %h exp 0", {ia.mem_addr, ia.mem_wdata, ia.mem_we}); else passed++;
    checks++; if ({ib.mem_req, ib.timeout, ib.if_ready, ib.d_ready} !== 4'b0000) $display("FAIL rst_b got %b exp 0000", {ib.mem_req, ib.timeout, ib.if_ready, ib.d_ready}); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only();
    ia.if_req = 1; ia.if_addr = 32'h40;
    tick(); // edge 1: grant
    checks++; if ({ia.mem_req, ia.mem_we} !== 2'b10) $display("FAIL fetch_grant req/we got %b exp 10", {ia.mem_req, ia.mem_we}); else passed++;
    checks++; if (ia.mem_addr !== 32'h40) $display("FAIL fetch_addr got %h exp 00000040", ia.mem_addr); else passed++;
    tick(); // edge 2
    tick(); // edge 3: ack now, two cycles after mem_req rose
    checks++; if ({ia.mem_req, ia.if_ready} !== 2'b10) $display("FAIL fetch_wait got %b exp 10", {ia.mem_req, ia.if_ready}); else passed++;
    ia.mem_ack = 1; ia.mem_rdata = 32'h2010_0005;
    tick(); // edge 4
    checks++; if (ia.if_ready !== 1'b1) $display("FAIL fetch_ready got %b exp 1", ia.if_ready); else passed++;
    checks++; if (ia.if_rdata !== 32'h2010_0005) $display("FAIL fetch_rdata got %h exp 20100005", ia.if_rdata); else passed++;
    checks++; if ({ia.mem_req, ia.d_ready, ia.timeout} !== 3'b000) $display("FAIL fetch_done got %b exp 000", {ia.mem_req, ia.d_ready, ia.timeout}); else passed++;
    ia.mem_ack = 0; // if_req still high during the ready cycle
    tick(); // edge 5: bubble, no regrant and ready is a single pulse
    checks++; if ({ia.mem_req, ia.if_ready} !== 2'b00) $display("FAIL fetch_bubble got %b exp 00", {ia.mem_req, ia.if_ready}); else passed++;
    ia.if_req = 0;
    tick();
  endtask

  task automatic test_priority();
    ia.if_req = 1; ia.if_addr = 32'h100;
    ia.d_req = 1; ia.d_we = 1; ia.d_addr = 32'h80; ia.d_wdata = 32'hDEAD_BEEF;
    tick(); // data wins
    checks++; if ({ia.mem_req, ia.mem_we} !== 2'b11) $display("FAIL prio_grant req/we got %b exp 11", {ia.mem_req, ia.mem_we}); else passed++;
    checks++; if (ia.mem_addr !== 32'h80) $display("FAIL prio_addr got %h exp 00000080", ia.mem_addr); else passed++;
    checks++; if (ia.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL prio_wdata got %h exp deadbeef", ia.mem_wdata); else passed++;
    ia.mem_ack = 1; ia.mem_rdata = 32'h0000_1234;
    tick();
    checks++; if ({ia.d_ready, ia.if_ready, ia.mem_req} !== 3'b100) $display("FAIL prio_d_ready got %b exp 100", {ia.d_ready, ia.if_ready, ia.mem_req}); else passed++;
    checks++; if (ia.d_rdata !== 32'h0000_1234) $display("FAIL prio_d_rdata got %h exp 00001234", ia.d_rdata); else passed++;
    ia.mem_ack = 0;
    tick(); // bubble
    checks++; if (ia.mem_req !== 1'b0) $display("FAIL prio_bubble got %b exp 0", ia.mem_req); else passed++;
    ia.d_req = 0;
    tick(); // fetch granted
    checks++; if ({ia.mem_req, ia.mem_we} !== 2'b10) $display("FAIL prio_if_grant got %b exp 10", {ia.mem_req, ia.mem_we}); else passed++;
    checks++; if (ia.mem_addr !== 32'h100) $display("FAIL prio_if_addr got %h exp 00000100", ia.mem_addr); else passed++;
    ia.mem_ack = 1; ia.mem_rdata = 32'hCAFE_0001;
    tick();
    checks++; if ({ia.if_ready, ia.d_ready} !== 2'b10) $display("FAIL prio_if_ready got %b exp 10", {ia.if_ready, ia.d_ready}); else passed++;
    checks++; if (ia.if_rdata !== 32'hCAFE_0001) $display("FAIL prio_if_rdata got %h exp cafe0001", ia.if_rdata); else passed++;
    checks++; if (ia.d_rdata !== 32'h0000_1234) $display("FAIL prio_d_hold got %h exp 00001234", ia.d_rdata); else passed++;
    ia.mem_ack = 0; ia.if_req = 0;
    tick(); tick();
  endtask

  task automatic test_spurious_ack();
    ia.mem_ack = 1; ia.mem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++; if ({ia.mem_req, ia.if_ready, ia.d_ready, ia.timeout} !== 4'b0000) $display("FAIL spur_ctrl got %b exp 0000", {ia.mem_req, ia.if_ready, ia.d_ready, ia.timeout}); else passed++;
    checks++; if (ia.if_rdata !== 32'hCAFE_0001) $display("FAIL spur_rdata got %h exp cafe0001", ia.if_rdata); else passed++;
    ia.mem_ack = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic        exp_req, exp_ifr, exp_dr;
    logic [31:0] exp_addr;
    ib.if_req = 1; ib.if_addr = 32'h200;
    ib.d_req = 1; ib.d_we = 0; ib.d_addr = 32'h300;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_req  = (k % 3 == 1);
      exp_dr   = (k == 2) || (k == 8);
      exp_ifr  = (k == 5) || (k == 11);
      exp_addr = ((k == 1) || (k == 7)) ? 32'h300 : 32'h200;
      checks++; if (ib.mem_req !== exp_req) $display("FAIL rr_req c%0d got %b exp %b", k, ib.mem_req, exp_req); else passed++;
      checks++; if ({ib.d_ready, ib.if_ready} !== {exp_dr, exp_ifr}) $display("FAIL rr_ready c%0d got %b exp %b", k, {ib.d_ready, ib.if_ready}, {exp_dr, exp_ifr}); else passed++;
      if (exp_req) begin
        checks++; if (ib.mem_addr !== exp_addr) $display("FAIL rr_addr c%0d got %h exp %h", k, ib.mem_addr, exp_addr); else passed++;
      end
      // memory answers in the same cycle the request is up
      ib.mem_ack = ib.mem_req;
      ib.mem_rdata = ib.mem_addr + 32'd1;
    end
    checks++; if ({ib.d_rdata, ib.if_rdata} !== {32'h301, 32'h201}) $display("FAIL rr_rdata got %h exp 0000030100000201", {ib.d_rdata, ib.if_rdata}); else passed++;
    ib.if_req = 0; ib.d_req = 0; ib.mem_ack = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    ib.d_req = 1; ib.d_we = 0; ib.d_addr = 32'h44;
    tick(); // mem_req rises
    checks++; if (ib.mem_req !== 1'b1) $display("FAIL to_grant got %b exp 1", ib.mem_req); else passed++;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++; if ({ib.mem_req, ib.timeout, ib.d_ready} !== 3'b100) $display("FAIL to_wait c%0d got %b exp 100", k, {ib.mem_req, ib.timeout, ib.d_ready}); else passed++;
    end
    tick(); // four cycles after mem_req rose
    checks++; if ({ib.timeout, ib.d_ready, ib.mem_req} !== 3'b110) $display("FAIL to_abort got %b exp 110", {ib.timeout, ib.d_ready, ib.mem_req}); else passed++;
    checks++; if (ib.d_rdata !== 32'h0) $display("FAIL to_rdata got %h exp 00000000", ib.d_rdata); else passed++;
    ib.d_req = 0;
    tick();
    checks++; if ({ib.timeout, ib.d_ready, ib.mem_req} !== 3'b000) $display("FAIL to_idle got %b exp 000", {ib.timeout, ib.d_ready, ib.mem_req}); else passed++;
    tick();
  endtask

  task automatic test_ack_at_limit();
    ib.if_req = 1; ib.if_addr = 32'h60;
    tick(); tick(); tick(); tick(); // cycle 4: last watchdog cycle
    checks++; if (ib.mem_req !== 1'b1) $display("FAIL lim_req got %b exp 1", ib.mem_req); else passed++;
    ib.mem_ack = 1; ib.mem_rdata = 32'h0000_5A5A;
    tick();
    checks++; if ({ib.if_ready, ib.timeout, ib.mem_req} !== 3'b100) $display("FAIL lim_done got %b exp 100", {ib.if_ready, ib.timeout, ib.mem_req}); else passed++;
    checks++; if (ib.if_rdata !== 32'h0000_5A5A) $display("FAIL lim_rdata got %h exp 00005a5a", ib.if_rdata); else passed++;
    ib.mem_ack = 0; ib.if_req = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    ia.if_req = 1; ia.if_addr = 32'h400;
    tick();
    checks++; if (ia.mem_req !== 1'b1) $display("FAIL rmid_grant got %b exp 1", ia.mem_req); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (ia.mem_req !== 1'b0) $display("FAIL rmid_async got %b exp 0", ia.mem_req); else passed++;
    tick();
    checks++; if ({ia.mem_req, ia.if_ready} !== 2'b00) $display("FAIL rmid_held got %b exp 00", {ia.mem_req, ia.if_ready}); else passed++;
    rst = 1'b1;
    tick(); // pending fetch granted again
    checks++; if ({ia.mem_req, ia.mem_addr} !== {1'b1, 32'h400}) $display("FAIL rmid_regrant got %h exp 100000400", {ia.mem_req, ia.mem_addr}); else passed++;
    ia.mem_ack = 1; ia.mem_rdata = 32'h0000_0077;
    tick();
    checks++; if ({ia.if_ready, ia.if_rdata} !== {1'b1, 32'h77}) $display("FAIL rmid_done got %h exp 100000077", {ia.if_ready, ia.if_rdata}); else passed++;
    ia.mem_ack = 0; ia.if_req = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_priority();
    test_spurious_ack();
    test_round_robin();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
